// File: rtl/hilo_pkg.sv
// Shared op encodings and FSM state type for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_iter_core.sv
// One-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// Result layout in acc: {hi, lo} product, or {remainder, quotient}.
module hilo_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               div_mode,
  input  logic [WIDTH-1:0]   lo_init,
  input  logic [WIDTH-1:0]   m_init,
  input  logic               step,
  output logic               last,
  output logic [2*WIDTH-1:0] acc
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_mode_q, div_mode_d;
  logic [WIDTH:0]     sum, shifted, diff;

  assign last = (cnt_q == CW'(WIDTH - 1));
  assign acc  = acc_q;

  always_comb begin
    acc_d      = acc_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    div_mode_d = div_mode_q;
    sum        = '0;
    shifted    = '0;
    diff       = '0;
    if (start) begin
      acc_d      = {{WIDTH{1'b0}}, lo_init};
      m_d        = m_init;
      cnt_d      = '0;
      div_mode_d = div_mode;
    end else if (step) begin
      cnt_d = cnt_q + CW'(1);
      if (div_mode_q) begin
        // Remainder lives in the upper half; quotient bits shift in at the bottom.
        shifted = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, m_q};
        if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else              acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q & {WIDTH{acc_q[0]}}};
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      div_mode_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_mode_q <= div_mode_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    m_q   <= m_d;
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register unit with iterative MULT/MULTU/DIV/DIVU and MTHI/MTLO.
// Optional in-flight abort enabled by defining HILO_FLUSH_EN.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic s);
    return s ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_dw(input logic [2*WIDTH-1:0] v, input logic s);
    return s ? -v : v;
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, rs_raw_q, rs_raw_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               neg_q, neg_d, rem_neg_q, rem_neg_d, div_q, div_d, div0_q, div0_d;
  logic               is_div, is_signed, is_muldiv, start, step, last, flush_act;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*WIDTH-1:0] acc, prod;

  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign is_muldiv = is_div || (op == OP_MULT) || (op == OP_MULTU);
  assign rs_mag    = cneg_w(rs, is_signed && rs[WIDTH-1]);
  assign rt_mag    = cneg_w(rt, is_signed && rt[WIDTH-1]);
  assign start     = (state_q == ST_IDLE) && op_valid && is_muldiv;
  assign step      = (state_q == ST_RUN);
  assign prod      = cneg_dw(acc, neg_q);

`ifdef HILO_FLUSH_EN
  assign flush_act = flush && (state_q != ST_IDLE);
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_act    = 1'b0;
`endif

  hilo_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (reset),
    .start    (start),
    .div_mode (is_div),
    .lo_init  (is_div ? rs_mag : rt_mag),
    .m_init   (is_div ? rt_mag : rs_mag),
    .step     (step),
    .last     (last),
    .acc      (acc)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div_d     = div_q;
    div0_d    = div0_q;
    rs_raw_d  = rs_raw_q;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          if (op == OP_MTHI) hi_d = rs;
          if (op == OP_MTLO) lo_d = rs;
          if (is_muldiv) begin
            neg_d     = is_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]);
            rem_neg_d = is_signed && rs[WIDTH-1];
            div_d     = is_div;
            div0_d    = is_div && (rt == '0);
            rs_raw_d  = rs;
            state_d   = (is_div && (rt == '0)) ? ST_FIX : ST_RUN;
          end
        end
      end
      ST_RUN: if (last) state_d = ST_FIX;
      ST_FIX: begin
        if (div0_q) begin
          hi_d = rs_raw_q;
          lo_d = '1;
        end else if (div_q) begin
          lo_d = cneg_w(acc[WIDTH-1:0], neg_q);
          hi_d = cneg_w(acc[2*WIDTH-1:WIDTH], rem_neg_q);
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // An abort discards whatever the FSM would have committed this edge.
    if (flush_act) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    neg_q     <= neg_d;
    rem_neg_q <= rem_neg_d;
    div_q     <= div_d;
    div0_q    <= div0_d;
    rs_raw_q  <= rs_raw_d;
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed cases plus randomized ops
// against a plain-arithmetic model of HI/LO.
module tb_hilo_muldiv_unit;

  localparam int W = 32;
  localparam logic [2:0] T_NOP = 3'd0, T_MULT = 3'd1, T_MULTU = 3'd2, T_DIV = 3'd3,
                         T_DIVU = 3'd4, T_MTHI = 3'd5, T_MTLO = 3'd6;

  logic         clk = 1'b0;
  logic         reset, op_valid, flush;
  logic [2:0]   op;
  logic [W-1:0] rs, rt, hi, lo;
  logic         busy, done;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .rs(rs), .rt(rt),
    .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  typedef struct {
    logic [W-1:0] hi, lo, pre_hi, pre_lo;
    int           cycles;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           checks = 0, errors = 0, busy_cnt = 0;
  logic [W-1:0] mhi = '0, mlo = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: stale HI/LO while busy, and result/latency on each done pulse.
  always @(negedge clk) begin
    if (busy) begin
      busy_cnt++;
      if (q.size() > 0) begin
        check("stale_hi", hi, q[0].pre_hi);
        check("stale_lo", lo, q[0].pre_lo);
      end
    end else if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        mon_e = q.pop_front();
        check("result_hi", hi, mon_e.hi);
        check("result_lo", lo, mon_e.lo);
        check("busy_cycles", 32'(busy_cnt), 32'(mon_e.cycles));
      end
      busy_cnt = 0;
    end else begin
      busy_cnt = 0;
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb;
    @(negedge clk);
    e.pre_hi = mhi;
    e.pre_lo = mlo;
    e.cycles = W + 1;
    e.hi     = mhi;
    e.lo     = mlo;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      T_MULT:  begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      T_MULTU: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      T_DIV: begin
        if (b == '0) begin e.hi = a; e.lo = '1; e.cycles = 1; end
        else begin p = sa / sb; e.lo = p[31:0]; p = sa % sb; e.hi = p[31:0]; end
      end
      T_DIVU: begin
        if (b == '0) begin e.hi = a; e.lo = '1; e.cycles = 1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      T_MTHI: mhi = a;
      T_MTLO: mlo = a;
      default: ;
    endcase
    if (o inside {T_MULT, T_MULTU, T_DIV, T_DIVU}) begin
      q.push_back(e);
      mhi = e.hi;
      mlo = e.lo;
    end
    op_valid = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    op_valid = 1'b0; op = T_NOP;
    if (o == T_MTHI || o == T_MTLO) begin
      check("mt_hi", hi, mhi);
      check("mt_lo", lo, mlo);
      check("mt_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout: got busy=%0d pending=%0d expected idle", busy, q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [W-1:0] pre_h, pre_l;
  logic [2:0]   rop;

  initial begin
    reset = 1'b1; op_valid = 1'b0; op = T_NOP; rs = '0; rt = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    issue(T_MTHI, 32'h1234_5678, '0);
    issue(T_MTLO, 32'h9ABC_DEF0, '0);
    check("mt_hi_const", hi, 32'h1234_5678);
    check("mt_lo_const", lo, 32'h9ABC_DEF0);

    issue(T_MULT, 32'hFFFF_FFFD, 32'd5);  wait_idle();
    check("mult_hi", hi, 32'hFFFF_FFFF);  check("mult_lo", lo, 32'hFFFF_FFF1);
    issue(T_MULTU, '1, '1);               wait_idle();
    check("multu_hi", hi, 32'hFFFF_FFFE); check("multu_lo", lo, 32'h0000_0001);
    issue(T_DIV, 32'hFFFF_FFF9, 32'd2);   wait_idle();
    check("div_hi", hi, 32'hFFFF_FFFF);   check("div_lo", lo, 32'hFFFF_FFFD);
    issue(T_DIVU, 32'd7, '0);             wait_idle();
    check("divu0_hi", hi, 32'd7);         check("divu0_lo", lo, 32'hFFFF_FFFF);
    issue(T_DIV, 32'h8000_0000, '1);      wait_idle();
    check("divovf_hi", hi, '0);           check("divovf_lo", lo, 32'h8000_0000);
    issue(T_DIV, 32'hFFFF_FFF0, '0);      wait_idle();
    check("div0_hi", hi, 32'hFFFF_FFF0);  check("div0_lo", lo, 32'hFFFF_FFFF);

    // Ops presented while busy must be ignored.
    issue(T_MULT, 32'd1234, 32'hFFFF_FF00);
    repeat (5) @(negedge clk);
    op_valid = 1'b1; op = T_MTHI; rs = 32'hDEAD_BEEF;
    @(negedge clk);
    op = T_DIVU; rs = 32'd99; rt = '0;
    @(negedge clk);
    op_valid = 1'b0; op = T_NOP;
    wait_idle();
    check("busy_ignore_hi", hi, mhi);
    check("busy_ignore_lo", lo, mlo);

    pre_h = mhi; pre_l = mlo;
    issue(T_MULTU, 32'hCAFE_F00D, 32'h0BAD_C0DE);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
`ifdef HILO_FLUSH_EN
    q.delete();
    mhi = pre_h; mlo = pre_l;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_hi", hi, mhi);
    check("flush_lo", lo, mlo);
    issue(T_DIVU, 32'd55, '0);
    flush = 1'b1;
    q.delete();
    mhi = pre_h; mlo = pre_l;
    @(negedge clk);
    flush = 1'b0;
    check("flushfix_busy", 32'(busy), 32'd0);
    check("flushfix_hi", hi, mhi);
    check("flushfix_lo", lo, mlo);
    repeat (3) @(negedge clk);
`else
    wait_idle();
    check("noflush_hi", hi, mhi);
    check("noflush_lo", lo, mlo);
`endif

    issue(T_MULTU, '1, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    mhi = '0; mlo = '0;
    check("rstmid_hi", hi, '0);
    check("rstmid_lo", lo, '0);
    check("rstmid_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    check("rstmid_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: rop = T_MULT;
        1: rop = T_MULTU;
        2: rop = T_DIV;
        3: rop = T_DIVU;
        4: rop = T_MTHI;
        default: rop = T_MTLO;
      endcase
      issue(rop, pick(), pick());
      if (rop != T_MTHI && rop != T_MTLO) wait_idle();
    end
    wait_idle();
    check("final_hi", hi, mhi);
    check("final_lo", lo, mlo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Parametrised HI/LO register unit for the MIPS pipeline. It holds the HI and LO registers and computes MULT/MULTU/DIV/DIVU results itself, using an iterative one-bit-per-cycle engine. It also services MTHI/MTLO writes. It sits beside the EX stage, and the hazard unit stalls MFHI/MFLO and new mul/div ops on `busy`.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `op_valid`  in  1  issue strobe for `op`.
- `op`  in  3  operation code; encodings are defined in `hilo_pkg`.
  - Operations: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `rs`  in  WIDTH  first operand: multiplicand, dividend, or MT data.
- `rt`  in  WIDTH  second operand: multiplier or divisor.
- `flush`  in  1  abort the in-flight operation (only when `HILO_FLUSH_EN` is defined).
- `hi`  out  WIDTH  HI register; holds the remainder after a divide.
- `lo`  out  WIDTH  LO register; holds the quotient after a divide.
- `busy`  out  1  engine occupied; HI/LO values are stale.
- `done`  out  1  one-cycle pulse in the cycle HI/LO take a new mul/div result.

## Operation
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0, state=IDLE.
- **States:** IDLE, RUN, FIX.
- **IDLE:**
  - `op_valid` with MTHI writes `rs` to HI at the edge; LO is unchanged.
  - `op_valid` with MTLO writes `rs` to LO; HI is unchanged.
  - `op_valid` with MULT/MULTU/DIV/DIVU latches the operands and goes to RUN.
  - NOP, or `op_valid`=0, holds state.
- **Operand latch:**
  - Signed ops latch the operand magnitudes.
  - The result sign is stored: product sign is `rs`^`rt` sign bits.
  - For DIV, the quotient sign is `rs`^`rt` and the remainder sign is the `rs` sign.
- **RUN:** WIDTH iterations, one per cycle, counted by an internal counter of width $clog2(WIDTH+1).
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient and remainder are WIDTH bits each.
  - After the last iteration, go to FIX.
- **FIX:** apply two's-complement sign correction.
  - Multiply: full 2·WIDTH product; HI gets the upper half, LO the lower half.
  - Divide: LO=quotient, HI=remainder.
  - Write HI/LO, pulse `done`, return to IDLE.
- **Divide by zero** (`rt`=0, any divide):
  - Skip RUN and go directly to FIX.
  - Result: HI=`rs` unmodified, LO=all ones.
- **Overflow case:** DIV with most-negative ÷ −1 gives LO=most-negative, HI=0. No trap is raised.
- **Ops while busy:** any `op_valid` (including MT*) is ignored. Issuing one is a protocol error the hazard unit must prevent.
- **Stale outputs:** HI/LO keep their pre-operation values throughout RUN/FIX.
- **Reset mid-operation:** takes precedence over everything. The engine returns to IDLE, HI/LO=0, and no `done` pulse is issued.

## Timing
- The operation is accepted at edge E0.
- `busy`:
  - goes high in the cycle after E0;
  - stays high for WIDTH+1 cycles (RUN×WIDTH, then FIX×1);
  - drops together with `done` being asserted in the cycle after FIX.
- HI/LO are updated at edge E0+WIDTH+1; for WIDTH=32, new results are readable 33 cycles after issue.
- Divide by zero:
  - `busy` is high for 1 cycle (FIX only);
  - result at E0+1.
- MTHI/MTLO: single cycle, visible the cycle after the edge, `busy` never asserted.
- A new operation may be issued in the same cycle `done` is high.
- `hi`/`lo`/`busy`/`done` are all registered outputs; there are no combinational paths from inputs.

## Configuration
- `HILO_FLUSH_EN` defined:
  - `flush`=1 in RUN or FIX returns the engine to IDLE at the next edge.
  - HI/LO are unchanged, and `done` is not pulsed.
  - `flush` in IDLE has no effect.
  - `reset` outranks `flush`.
  - `flush` outranks completion: if FIX and `flush` coincide, the result is discarded.
- `HILO_FLUSH_EN` not defined: the `flush` port exists but is ignored, and operations always complete.

## Structure
- `hilo_pkg` contains:
  - the `op` encoding constants (NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6);
  - the state enum typedef (IDLE/RUN/FIX).
- Sub-module `hilo_iter_core`:
  - holds the WIDTH-parametrised shift-add/shift-subtract datapath and the iteration counter;
  - the top level keeps the FSM, sign handling, the HI/LO registers and the MT writes.

## Test plan
- **Reset/MT:** reset, then MTHI 0x12345678 and MTLO 0x9ABCDEF0 → hi=0x12345678, lo=0x9ABCDEF0, `busy` never high.
- **MULT signed:** MULT rs=0xFFFFFFFD (−3), rt=5 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1; `done` pulses once; hi/lo unchanged in between.
- **MULTU:** MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- **DIV signed:** DIV 0xFFFFFFF9 (−7) ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **DIVU by zero:** DIVU 7 ÷ 0 → hi=7, lo=0xFFFFFFFF, result after 1 busy cycle.
- **Reset/flush mid-operation:**
  - MULTU issued, `reset` asserted at cycle 10 → hi=lo=0, `busy`=0, no `done`.
  - With `HILO_FLUSH_EN`: `flush` at cycle 10 → prior HI/LO retained, `busy`=0 next cycle.
  - Ops issued while busy are ignored.
